// File: rtl/fetch_sequencer_pkg.sv
// Shared encodings for the fetch front-end: FSM states, fetch-mux selects, reset PC.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    FS_BOOT     = 2'd0,
    FS_RUN      = 2'd1,
    FS_WAIT     = 2'd2,
    FS_REDIRECT = 2'd3
  } fs_state_e;

  localparam logic [1:0] NEXT_PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] NEXT_PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] NEXT_PC_SEL_JUMP   = 2'b10;
  localparam logic [1:0] NEXT_PC_SEL_HELD   = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !(&count_q)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front-end: owns the PC, arbitrates redirects vs. stalls and imem wait states,
// and drives pipeline write/flush controls plus stall/flush statistics.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  input  logic             load_use_i,
  input  logic             imem_ready_i,
  output logic             imem_req_o,
  output logic [31:0]      pc_o,
  output logic [1:0]       next_pc_sel_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  fs_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rpc_q, rpc_d;
  logic        stall_inc, flush_inc;

  // Branch (MEM stage) is older than jump (ID stage), so it always wins.
  logic        redir_req;
  logic [31:0] redir_tgt;
  assign redir_req = branch_taken_i | jump_i;
  assign redir_tgt = branch_taken_i ? branch_target_i : jump_target_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FS_BOOT;
      pc_q    <= RESET_PC & PC_ALIGN_MASK;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d & PC_ALIGN_MASK;
      rpc_q   <= rpc_d & PC_ALIGN_MASK;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_BOOT: state_d = FS_RUN;
      FS_RUN: begin
        if (redir_req)              state_d = imem_ready_i ? FS_RUN : FS_REDIRECT;
        else if (load_use_i)        state_d = FS_RUN;
        else if (!imem_ready_i)     state_d = FS_WAIT;
      end
      FS_WAIT: begin
        if (redir_req)              state_d = FS_REDIRECT;
        else if (imem_ready_i)      state_d = FS_RUN;
      end
      FS_REDIRECT: begin
        if (!branch_taken_i && imem_ready_i) state_d = FS_RUN;
      end
      default: state_d = FS_BOOT;
    endcase
  end

  always_comb begin
    imem_req_o    = 1'b1;
    next_pc_sel_o = NEXT_PC_SEL_SEQ;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    pc_d          = pc_q;
    rpc_d         = rpc_q;
    flush_inc     = 1'b0;
    unique case (state_q)
      FS_BOOT: begin
        imem_req_o    = 1'b0;
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
      end
      FS_RUN, FS_WAIT: begin
        if (redir_req) begin
          next_pc_sel_o = branch_taken_i ? NEXT_PC_SEL_BRANCH : NEXT_PC_SEL_JUMP;
          ifid_flush_o  = 1'b1;
          idex_flush_o  = branch_taken_i;
          exmem_flush_o = branch_taken_i;
          flush_inc     = 1'b1;
          // Only a ready fetch in RUN can retire the redirect now; otherwise park it.
          if (state_q == FS_RUN && imem_ready_i) begin
            pc_write_o = 1'b1;
            pc_d       = redir_tgt;
          end else begin
            rpc_d = redir_tgt;
          end
        end else if (state_q == FS_WAIT && !imem_ready_i) begin
          ifid_flush_o = 1'b1;
        end else if (load_use_i) begin
          idex_flush_o = 1'b1;
        end else if (!imem_ready_i) begin
          ifid_flush_o = 1'b1;
        end else begin
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          pc_d         = pc_q + 32'd4;
        end
      end
      FS_REDIRECT: begin
        // Whatever returns for the stale pc is wrong-path, so IF/ID stays bubbled.
        ifid_flush_o = 1'b1;
        if (branch_taken_i) begin
          idex_flush_o  = 1'b1;
          exmem_flush_o = 1'b1;
          flush_inc     = 1'b1;
          rpc_d         = branch_target_i;
        end else if (imem_ready_i) begin
          next_pc_sel_o = NEXT_PC_SEL_HELD;
          pc_write_o    = 1'b1;
          pc_d          = rpc_q;
        end
      end
      default: ;
    endcase
  end

  assign stall_inc = (state_q == FS_RUN || state_q == FS_WAIT) && !pc_write_o;
  assign pc_o      = pc_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (stall_inc),
    .count_o(stall_count_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (flush_inc),
    .count_o(flush_count_o)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle model of the fetch rules plus pinned literal checks.
module tb_fetch_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             branch_taken = 1'b0, jump = 1'b0, load_use = 1'b0, imem_ready = 1'b1;
  logic [31:0]      branch_target = '0, jump_target = '0;
  logic             imem_req, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic [31:0]      pc;
  logic [1:0]       next_pc_sel;
  logic [CNT_W-1:0] stall_count, flush_count;

  int total = 0;
  int passed = 0;

  fetch_sequencer #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .jump_i         (jump),
    .jump_target_i  (jump_target),
    .load_use_i     (load_use),
    .imem_ready_i   (imem_ready),
    .imem_req_o     (imem_req),
    .pc_o           (pc),
    .next_pc_sel_o  (next_pc_sel),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_flush_o   (idex_flush),
    .exmem_flush_o  (exmem_flush),
    .stall_count_o  (stall_count),
    .flush_count_o  (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  // Model: mode 0 boot, 1 running, 2 waiting on imem, 3 holding a parked redirect.
  int          m_mode = 0, n_mode = 0;
  logic [31:0] m_pc = '0, n_pc = '0, m_park = '0, n_park = '0;
  int          m_sc = 0, n_sc = 0, m_fc = 0, n_fc = 0;
  int          sat_max = (1 << CNT_W) - 1;

  always @(negedge clk) begin : compare
    logic e_req, e_pw, e_iw, e_f1, e_f2, e_f3;
    logic [1:0] e_sel;
    logic [31:0] tgt;
    e_req = (m_mode != 0);
    e_sel = 2'b00; e_pw = 0; e_iw = 0; e_f1 = 0; e_f2 = 0; e_f3 = 0;
    n_mode = m_mode; n_pc = m_pc; n_park = m_park; n_sc = m_sc; n_fc = m_fc;
    tgt = branch_taken ? branch_target : jump_target;
    if (m_mode == 0) begin
      e_f1 = 1; e_f2 = 1; e_f3 = 1; n_mode = 1;
    end else if (m_mode == 3) begin
      e_f1 = 1;
      if (branch_taken) begin
        e_f2 = 1; e_f3 = 1; n_park = branch_target; n_fc = m_fc + 1;
      end else if (imem_ready) begin
        e_sel = 2'b11; e_pw = 1; n_pc = m_park; n_mode = 1;
      end
    end else begin
      if (branch_taken || jump) begin
        e_sel = branch_taken ? 2'b01 : 2'b10;
        e_f1 = 1; e_f2 = branch_taken; e_f3 = branch_taken; n_fc = m_fc + 1;
        if (m_mode == 1 && imem_ready) begin e_pw = 1; n_pc = tgt; n_mode = 1; end
        else begin n_park = tgt; n_mode = 3; end
      end else if (!imem_ready && (m_mode == 2 || !load_use)) begin
        e_f1 = 1; n_mode = 2;
      end else if (load_use) begin
        e_f2 = 1; n_mode = 1;
      end else begin
        e_pw = 1; e_iw = 1; n_pc = m_pc + 4; n_mode = 1;
      end
      if (!e_pw) n_sc = m_sc + 1;
    end
    n_pc   = n_pc & 32'hFFFF_FFFC;
    n_park = n_park & 32'hFFFF_FFFC;
    if (n_sc > sat_max) n_sc = sat_max;
    if (n_fc > sat_max) n_fc = sat_max;
    chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    chk("pc", pc, m_pc);
    chk("next_pc_sel", {30'b0, next_pc_sel}, {30'b0, e_sel});
    chk("pc_write", {31'b0, pc_write}, {31'b0, e_pw});
    chk("ifid_write", {31'b0, ifid_write}, {31'b0, e_iw});
    chk("flushes", {29'b0, ifid_flush, idex_flush, exmem_flush}, {29'b0, e_f1, e_f2, e_f3});
    chk("stall_count", 32'(stall_count), 32'(m_sc));
    chk("flush_count", 32'(flush_count), 32'(m_fc));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_pc <= '0; m_park <= '0; m_sc <= 0; m_fc <= 0;
    end else begin
      m_mode <= n_mode; m_pc <= n_pc; m_park <= n_park; m_sc <= n_sc; m_fc <= n_fc;
    end
  end

  task automatic cyc(input logic b, input logic [31:0] bt, input logic j,
                     input logic [31:0] jt, input logic lu, input logic rdy);
    @(posedge clk); #1;
    branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    load_use = lu; imem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #11;
    chk("reset pc", pc, 32'h0);
    chk("reset imem_req", {31'b0, imem_req}, 32'h0);
    chk("reset flushes", {29'b0, ifid_flush, idex_flush, exmem_flush}, 32'h7);
    #1 rst_n = 1'b1;

    idle();                 chk("t1 pc0", pc, 32'h0); chk("t1 sel", {30'b0, next_pc_sel}, 0);
    idle();                 chk("t1 pc4", pc, 32'h4);
    cyc(1, 32'h100, 0, 0, 0, 1);
    chk("t2 pc8", pc, 32'h8); chk("t2 sel", {30'b0, next_pc_sel}, 1);
    chk("t2 flushes", {29'b0, ifid_flush, idex_flush, exmem_flush}, 32'h7);
    idle();                 chk("t2 pc", pc, 32'h100); chk("t2 fc", 32'(flush_count), 1);
    chk("t2 flush drop", {31'b0, exmem_flush}, 0);

    cyc(0, 0, 0, 0, 1, 1);  chk("t3 iw", {31'b0, ifid_write}, 0); chk("t3 idex", {31'b0, idex_flush}, 1);
    cyc(0, 0, 0, 0, 1, 1);  chk("t3 pc held", pc, 32'h104);
    idle();                 chk("t3 pc", pc, 32'h104); chk("t3 sc", 32'(stall_count), 2);

    cyc(1, 32'h200, 1, 32'h300, 1, 1);
    chk("t4 sel", {30'b0, next_pc_sel}, 1);
    idle();                 chk("t4 pc", pc, 32'h200); chk("t4 fc", 32'(flush_count), 2);

    cyc(0, 0, 0, 0, 0, 0);  chk("t5 pc", pc, 32'h204); chk("t5 ifid_flush", {31'b0, ifid_flush}, 1);
    cyc(1, 32'h40, 0, 0, 0, 0); chk("t5 pc held a", pc, 32'h204);
    cyc(0, 0, 0, 0, 0, 0);  chk("t5 pc held b", pc, 32'h204);
    cyc(0, 0, 0, 0, 0, 1);  chk("t5 sel", {30'b0, next_pc_sel}, 3);
    idle();                 chk("t5 pc", pc, 32'h40); chk("t5 fc", 32'(flush_count), 3);

    cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 1); chk("t6 sel", {30'b0, next_pc_sel}, 2);
    idle();                 chk("t6 pc max", pc, 32'hFFFF_FFFC);
    idle();                 chk("t6 wrap", pc, 32'h0);
    cyc(0, 0, 1, 32'h123, 0, 1);
    idle();                 chk("align", pc, 32'h120);

    cyc(0, 0, 1, 32'h700, 0, 0);
    cyc(1, 32'h500, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h900, 0, 1); chk("overwrite sel", {30'b0, next_pc_sel}, 3);
    idle();                 chk("overwrite pc", pc, 32'h500);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);  chk("wait lu idex", {31'b0, idex_flush}, 1);
    idle();                 chk("wait lu pc", pc, 32'h504);

    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 1);
    chk("stall sat", 32'(stall_count), 32'hF);

    for (int i = 0; i < 40; i++)
      cyc($urandom_range(7) == 0, $urandom, $urandom_range(7) == 0, $urandom,
          $urandom_range(3) == 0, $urandom_range(3) != 0);

    cyc(1, 32'h80, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid pc", pc, 32'h0);
    chk("rst mid counts", {16'(stall_count), 16'(flush_count)}, 32'h0);
    chk("rst mid flushes", {29'b0, ifid_flush, idex_flush, exmem_flush}, 32'h7);
    @(posedge clk); #3 rst_n = 1'b1;
    idle();                 chk("post rst pc", pc, 32'h0);
    idle();                 chk("post rst pc4", pc, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
